// File: rtl/screen_request_ctrl_pkg.sv
// screen_request_ctrl_pkg: shared FSM encoding, screen geometry and image indices
// for the screen request controller and its debounce sub-module.
package screen_request_ctrl_pkg;
    localparam logic [2:0] ST_BOOT      = 3'd0;
    localparam logic [2:0] ST_IDLE      = 3'd1;
    localparam logic [2:0] ST_ISSUE     = 3'd2;
    localparam logic [2:0] ST_WAIT_LOW  = 3'd3;
    localparam logic [2:0] ST_WAIT_DONE = 3'd4;
    localparam int SCREEN_W     = 160;
    localparam int SCREEN_H     = 120;
    localparam int FRAME_PIXELS = SCREEN_W * SCREEN_H;
    localparam logic [1:0] IMG_TITLE  = 2'd0;
    localparam logic [1:0] IMG_LEVEL1 = 2'd1;
    localparam logic [1:0] IMG_LEVEL2 = 2'd2;
endpackage

// File: rtl/screen_request_ctrl_sync_debounce.sv
// screen_request_ctrl_sync_debounce: 2-flop synchroniser followed by a saturating
// debounce counter.
// Ports: clk, rst_n (async active-low); raw_i asynchronous input;
// level_o debounced value; changed_o one-cycle pulse when level_o takes a new value.
module screen_request_ctrl_sync_debounce
    import screen_request_ctrl_pkg::*;
#(
    parameter int WIDTH           = 1,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] raw_i,
    output logic [WIDTH-1:0] level_o,
    output logic             changed_o
);
    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    logic [WIDTH-1:0] s1_q, s2_q, cand_q, level_q;
    logic [CW-1:0]    cnt_q;
    logic             changed_q;
    // The commit fires on the cycle the counter steps onto DEBOUNCE_CYCLES-1,
    // giving DEBOUNCE_CYCLES+2 cycles from a clean raw edge to the new level.
    logic stable;
    assign stable = (s2_q == cand_q) && (cnt_q >= CW'(DEBOUNCE_CYCLES - 2));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q      <= '0;
            s2_q      <= '0;
            cand_q    <= '0;
            level_q   <= '0;
            cnt_q     <= '0;
            changed_q <= 1'b0;
        end else begin
            s1_q      <= raw_i;
            s2_q      <= s1_q;
            changed_q <= stable && (cand_q != level_q);
            if (s2_q != cand_q) begin
                cand_q <= s2_q;
                cnt_q  <= '0;
            end else if (cnt_q != CW'(DEBOUNCE_CYCLES - 1)) begin
                cnt_q <= cnt_q + CW'(1);
            end
            if (stable) level_q <= cand_q;
        end
    end
    assign level_o   = level_q;
    assign changed_o = changed_q;
endmodule

// File: rtl/screen_request_ctrl.sv
// screen_request_ctrl: debounces the board switches and sequences full-screen
// image draws, with a one-deep change queue and forced redraw.
// Ports: clk, rst_n (async active-low); sw_level_i image select switches;
// redraw_n_i active-low redraw button; draw_done_i drawer done level;
// draw_start_o one-cycle draw pulse; image_sel_o image index; busy_o frame in
// progress; pending_o change queued; ack_error_o sticky missing-ack flag.
module screen_request_ctrl
    import screen_request_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int NUM_IMAGES      = 3,
    parameter int ACK_TIMEOUT     = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] sw_level_i,
    input  logic       redraw_n_i,
    input  logic       draw_done_i,
    output logic       draw_start_o,
    output logic [1:0] image_sel_o,
    output logic       busy_o,
    output logic       pending_o,
    output logic       ack_error_o
);
    localparam int AW = $clog2(ACK_TIMEOUT + 1);
    logic [1:0]    sw_lvl;
    logic [0:0]    rd_lvl;
    logic          sw_chg, rd_chg, change_req, redraw_req;
    logic [2:0]    state_q, state_d;
    logic [1:0]    image_sel_q, image_sel_d, queue_q, queue_d;
    logic          pending_q, pending_d, ack_error_q, ack_error_d;
    logic [AW-1:0] ack_cnt_q, ack_cnt_d;
    screen_request_ctrl_sync_debounce #(.WIDTH(2), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw (
        .clk(clk), .rst_n(rst_n), .raw_i(sw_level_i), .level_o(sw_lvl), .changed_o(sw_chg)
    );
    screen_request_ctrl_sync_debounce #(.WIDTH(1), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_rd (
        .clk(clk), .rst_n(rst_n), .raw_i(redraw_n_i), .level_o(rd_lvl), .changed_o(rd_chg)
    );
    assign change_req = (int'(sw_lvl) < NUM_IMAGES) && (sw_lvl != image_sel_q) &&
                        !(pending_q && (sw_lvl == queue_q));
    assign redraw_req = rd_chg && !rd_lvl[0];
    always_comb begin
        state_d     = state_q;
        image_sel_d = image_sel_q;
        queue_d     = queue_q;
        pending_d   = pending_q;
        ack_cnt_d   = ack_cnt_q;
        ack_error_d = ack_error_q;
        // Outside IDLE every request lands in the queue; a completing frame
        // below then sees this cycle's request as well.
        if (state_q != ST_IDLE) begin
            if (change_req) begin
                pending_d = 1'b1;
                queue_d   = sw_lvl;
            end else if (sw_chg && pending_q && (sw_lvl == image_sel_q)) begin
                pending_d = 1'b0;
            end else if (redraw_req) begin
                pending_d = 1'b1;
                queue_d   = image_sel_q;
            end
        end
        case (state_q)
            ST_BOOT: begin
                state_d     = ST_ISSUE;
                image_sel_d = IMG_TITLE;
            end
            ST_IDLE: if (change_req || redraw_req) begin
                state_d     = ST_ISSUE;
                image_sel_d = change_req ? sw_lvl : image_sel_q;
            end
            ST_ISSUE: begin
                state_d   = ST_WAIT_LOW;
                ack_cnt_d = '0;
            end
            // done is still high from the previous frame here, so wait for it to
            // fall before treating a high level as completion.
            ST_WAIT_LOW: begin
                if (!draw_done_i) begin
                    state_d = ST_WAIT_DONE;
                end else if (ack_cnt_q == AW'(ACK_TIMEOUT - 1)) begin
                    state_d     = ST_WAIT_DONE;
                    ack_error_d = 1'b1;
                end else begin
                    ack_cnt_d = ack_cnt_q + AW'(1);
                end
            end
            ST_WAIT_DONE: if (draw_done_i) begin
                state_d = pending_d ? ST_ISSUE : ST_IDLE;
                if (pending_d) begin
                    image_sel_d = queue_d;
                    pending_d   = 1'b0;
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_BOOT;
            image_sel_q <= IMG_TITLE;
            queue_q     <= IMG_TITLE;
            pending_q   <= 1'b0;
            ack_cnt_q   <= '0;
            ack_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            image_sel_q <= image_sel_d;
            queue_q     <= queue_d;
            pending_q   <= pending_d;
            ack_cnt_q   <= ack_cnt_d;
            ack_error_q <= ack_error_d;
        end
    end
    assign draw_start_o = (state_q == ST_ISSUE);
    assign busy_o       = (state_q == ST_ISSUE) || (state_q == ST_WAIT_LOW) || (state_q == ST_WAIT_DONE);
    assign image_sel_o  = image_sel_q;
    assign pending_o    = pending_q;
    assign ack_error_o  = ack_error_q;
endmodule

// File: tb/tb_screen_request_ctrl.sv
// tb_screen_request_ctrl: directed scenarios against a simple drawer model.
module tb_screen_request_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] sw = 2'd0;
    logic       redraw_n = 1'b1;
    logic       draw_done;
    logic       draw_start, busy, pending, ack_error;
    logic [1:0] image_sel;
    logic       stuck = 1'b0;
    int         dcnt;
    int         starts = 0;
    int         checks = 0;
    int         fails = 0;

    screen_request_ctrl #(.DEBOUNCE_CYCLES(4), .NUM_IMAGES(3), .ACK_TIMEOUT(7)) dut (
        .clk(clk), .rst_n(rst_n), .sw_level_i(sw), .redraw_n_i(redraw_n),
        .draw_done_i(draw_done), .draw_start_o(draw_start), .image_sel_o(image_sel),
        .busy_o(busy), .pending_o(pending), .ack_error_o(ack_error)
    );

    always #5 clk = ~clk;

    // Drawer: done falls the cycle after start and rises 20 cycles later.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            draw_done <= 1'b1;
            dcnt      <= 0;
        end else if (draw_start && !stuck) begin
            draw_done <= 1'b0;
            dcnt      <= 20;
        end else if (dcnt > 0) begin
            dcnt <= dcnt - 1;
            if (dcnt == 1) draw_done <= 1'b1;
        end
    end

    always @(posedge clk) if (draw_start) starts <= starts + 1;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            tick(1);
            n++;
        end
    endtask

    task automatic test_reset();
        int n, s0;
        rst_n = 1'b0; sw = 2'd0; redraw_n = 1'b1;
        #12;
        checks++; if ({draw_start, busy, pending, ack_error, image_sel} !== 6'd0) begin
            $display("FAIL reset_outputs: got %b expected 000000", {draw_start, busy, pending, ack_error, image_sel}); fails++; end
        @(posedge clk); #1;
        rst_n = 1'b1;
        s0 = starts;
        tick(1);
        checks++; if (draw_start !== 1'b1) begin
            $display("FAIL boot_start: got %b expected 1", draw_start); fails++; end
        checks++; if (image_sel !== 2'd0) begin
            $display("FAIL boot_image: got %0d expected 0", image_sel); fails++; end
        n = 1;
        while (busy && n < 100) begin
            tick(1);
            if (busy) n++;
        end
        checks++; if (n !== 22) begin
            $display("FAIL boot_busy_cycles: got %0d expected 22", n); fails++; end
        checks++; if (starts - s0 !== 1) begin
            $display("FAIL boot_start_count: got %0d expected 1", starts - s0); fails++; end
    endtask

    task automatic test_clean_change();
        int s0 = starts;
        sw = 2'd2;
        tick(6);
        checks++; if (draw_start !== 1'b0) begin
            $display("FAIL clean_early_start: got %b expected 0", draw_start); fails++; end
        tick(1);
        checks++; if (draw_start !== 1'b1) begin
            $display("FAIL clean_start: got %b expected 1", draw_start); fails++; end
        checks++; if (image_sel !== 2'd2) begin
            $display("FAIL clean_image: got %0d expected 2", image_sel); fails++; end
        wait_idle();
        checks++; if (busy !== 1'b0) begin
            $display("FAIL clean_idle: got %b expected 0", busy); fails++; end
        checks++; if (starts - s0 !== 1) begin
            $display("FAIL clean_start_count: got %0d expected 1", starts - s0); fails++; end
    endtask

    task automatic test_bounce();
        int s0 = starts;
        sw = 2'd1; tick(2);
        sw = 2'd0; tick(2);
        sw = 2'd1; tick(6);
        checks++; if (starts - s0 !== 0) begin
            $display("FAIL bounce_early_start: got %0d starts expected 0", starts - s0); fails++; end
        tick(1);
        checks++; if (draw_start !== 1'b1 || image_sel !== 2'd1) begin
            $display("FAIL bounce_start: got start=%b image=%0d expected start=1 image=1", draw_start, image_sel); fails++; end
        wait_idle();
        checks++; if (starts - s0 !== 1) begin
            $display("FAIL bounce_start_count: got %0d expected 1", starts - s0); fails++; end
    endtask

    task automatic test_queue();
        int n, s0;
        s0 = starts;
        redraw_n = 1'b0;
        tick(7);
        checks++; if (draw_start !== 1'b1 || image_sel !== 2'd1) begin
            $display("FAIL redraw_start: got start=%b image=%0d expected start=1 image=1", draw_start, image_sel); fails++; end
        tick(1);
        redraw_n = 1'b1; sw = 2'd2;
        tick(8);
        sw = 2'd0;
        tick(8);
        checks++; if (pending !== 1'b1) begin
            $display("FAIL queue_pending: got %b expected 1", pending); fails++; end
        checks++; if (image_sel !== 2'd1 || busy !== 1'b1) begin
            $display("FAIL queue_hold: got image=%0d busy=%b expected image=1 busy=1", image_sel, busy); fails++; end
        n = 0;
        while (!draw_done && n < 50) begin
            tick(1);
            n++;
        end
        checks++; if (draw_done !== 1'b1 || draw_start !== 1'b0 || image_sel !== 2'd1) begin
            $display("FAIL queue_done_cycle: got done=%b start=%b image=%0d expected 1 0 1", draw_done, draw_start, image_sel); fails++; end
        tick(1);
        checks++; if (draw_start !== 1'b1 || image_sel !== 2'd0) begin
            $display("FAIL queue_reissue: got start=%b image=%0d expected start=1 image=0", draw_start, image_sel); fails++; end
        checks++; if (pending !== 1'b0) begin
            $display("FAIL queue_pending_clear: got %b expected 0", pending); fails++; end
        wait_idle();
        checks++; if (starts - s0 !== 2) begin
            $display("FAIL queue_start_count: got %0d expected 2", starts - s0); fails++; end
    endtask

    task automatic test_invalid();
        int s0 = starts;
        sw = 2'd3;
        tick(15);
        checks++; if (starts - s0 !== 0 || busy !== 1'b0) begin
            $display("FAIL invalid_start: got starts=%0d busy=%b expected 0 0", starts - s0, busy); fails++; end
        checks++; if (image_sel !== 2'd0) begin
            $display("FAIL invalid_image: got %0d expected 0", image_sel); fails++; end
        sw = 2'd0;
        tick(10);
        checks++; if (starts - s0 !== 0) begin
            $display("FAIL same_image_start: got %0d expected 0", starts - s0); fails++; end
    endtask

    task automatic test_ack_timeout();
        int s0 = starts;
        stuck = 1'b1;
        redraw_n = 1'b0;
        tick(7);
        checks++; if (draw_start !== 1'b1) begin
            $display("FAIL ack_start: got %b expected 1", draw_start); fails++; end
        tick(1);
        redraw_n = 1'b1;
        tick(6);
        checks++; if (ack_error !== 1'b0) begin
            $display("FAIL ack_early: got %b expected 0", ack_error); fails++; end
        tick(1);
        checks++; if (ack_error !== 1'b1) begin
            $display("FAIL ack_error_set: got %b expected 1", ack_error); fails++; end
        tick(1);
        checks++; if (busy !== 1'b0 || ack_error !== 1'b1) begin
            $display("FAIL ack_complete: got busy=%b ack_error=%b expected 0 1", busy, ack_error); fails++; end
        checks++; if (starts - s0 !== 1) begin
            $display("FAIL ack_start_count: got %0d expected 1", starts - s0); fails++; end
        stuck = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        int n = 0;
        sw = 2'd1;
        tick(7);
        checks++; if (draw_start !== 1'b1 || image_sel !== 2'd1) begin
            $display("FAIL mid_start: got start=%b image=%0d expected start=1 image=1", draw_start, image_sel); fails++; end
        tick(8);
        checks++; if (busy !== 1'b1 || draw_done !== 1'b0) begin
            $display("FAIL mid_wait_done: got busy=%b done=%b expected 1 0", busy, draw_done); fails++; end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if ({draw_start, busy, pending, ack_error, image_sel} !== 6'd0) begin
            $display("FAIL mid_reset_outputs: got %b expected 000000", {draw_start, busy, pending, ack_error, image_sel}); fails++; end
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick(1);
        checks++; if (draw_start !== 1'b1 || image_sel !== 2'd0) begin
            $display("FAIL mid_reboot: got start=%b image=%0d expected start=1 image=0", draw_start, image_sel); fails++; end
        tick(9);
        checks++; if (pending !== 1'b1 || image_sel !== 2'd0) begin
            $display("FAIL mid_pending: got pending=%b image=%0d expected 1 0", pending, image_sel); fails++; end
        while (!draw_start && n < 60) begin
            tick(1);
            n++;
        end
        checks++; if (draw_start !== 1'b1 || image_sel !== 2'd1) begin
            $display("FAIL mid_requeue: got start=%b image=%0d expected start=1 image=1", draw_start, image_sel); fails++; end
        wait_idle();
        checks++; if (busy !== 1'b0 || pending !== 1'b0) begin
            $display("FAIL mid_final_idle: got busy=%b pending=%b expected 0 0", busy, pending); fails++; end
    endtask

    initial begin
        test_reset();
        test_clean_change();
        test_bounce();
        test_queue();
        test_invalid();
        test_ack_timeout();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
